period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/period_meter_edge_sync.sv | 38 +++
 rtl/period_meter.sv | 84 ++++++++
 tb/tb_period_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM state encoding and default build parameters for period_meter.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [31:0] DEF_TIMEOUT     = 32'd100000000;
    localparam int          DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// edge_sync: synchronizes an async input and flags its rising edges.
//   clock_in - sole clock
//   clear    - synchronous active-high reset
//   d        - asynchronous input
//   level    - synchronized level, time-aligned with rise
//   rise     - one-cycle pulse per detected rising edge
module edge_sync
    import period_meter_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clock_in,
    input  logic clear,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              dly;

    // Everything resets high so a level held across clear cannot look like an edge.
    always_ff @(posedge clock_in) begin
        if (clear) begin
            sync <= '1;
            dly  <= 1'b1;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            dly  <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~dly;
        end
    end

    // dly and rise both reflect the same sample of the last stage.
    assign level = dly;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow async square wave in clock_in cycles.
//   clock_in     - sole clock
//   clear        - synchronous active-high reset
//   sig_in       - asynchronous signal to measure
//   period       - cycles between the last two rising edges
//   high_time    - cycles sig_in was high within that period
//   period_valid - one-cycle pulse when period/high_time update
//   timeout      - sticky, set when no edge arrives within TIMEOUT cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter logic [31:0] TIMEOUT     = DEF_TIMEOUT,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        clock_in,
    input  logic        clear,
    input  logic        sig_in,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        period_valid,
    output logic        timeout
);

    logic        level, rise;
    logic        arm, capture, expire;
    logic [31:0] cnt, hcnt;
    state_t      state, state_nx;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock_in(clock_in),
        .clear   (clear),
        .d       (sig_in),
        .level   (level),
        .rise    (rise)
    );

    always_ff @(posedge clock_in) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    // An edge on the cycle cnt reaches TIMEOUT still counts as a valid period.
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = rise ? MEASURE : IDLE;
        else               state_nx = (!rise && cnt == TIMEOUT) ? IDLE : MEASURE;
    end

    always_comb begin
        arm     = (state == IDLE) && rise;
        capture = (state == MEASURE) && rise;
        expire  = (state == MEASURE) && !rise && (cnt == TIMEOUT);
    end

    always_ff @(posedge clock_in) begin
        if (clear) begin
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= capture;
            if (arm || capture) begin
                cnt  <= 32'd1;
                hcnt <= 32'd1;
            end else if (expire) begin
                cnt  <= '0;
                hcnt <= '0;
            end else if (state == MEASURE) begin
                cnt  <= cnt + 32'd1;
                hcnt <= hcnt + {31'b0, level};
            end
            if (capture) begin
                period    <= cnt;
                high_time <= hcnt;
                timeout   <= 1'b0;
            end
            if (expire) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter.
module tb_period_meter;
    import period_meter_pkg::*;

    logic        clk = 1'b0;
    logic        clr [3];
    logic        sig [3];
    logic        pv  [3];
    logic        to  [3];
    logic [31:0] per [3];
    logic [31:0] ht  [3];
    int          tests = 0;
    int          fails = 0;

    logic        pv_prev [3];
    bit          wide  = 1'b0;
    bit          rnd   = 1'b0;
    int          rnd_n = 0;
    logic [31:0] pmin = '1, pmax = '0, hmin = '1, hmax = '0;

    always #10 clk = ~clk;

    period_meter #(.TIMEOUT(DEF_TIMEOUT), .SYNC_STAGES(2)) dut_a (
        .clock_in(clk), .clear(clr[0]), .sig_in(sig[0]), .period(per[0]),
        .high_time(ht[0]), .period_valid(pv[0]), .timeout(to[0]));

    period_meter #(.TIMEOUT(32'd20), .SYNC_STAGES(2)) dut_b (
        .clock_in(clk), .clear(clr[1]), .sig_in(sig[1]), .period(per[1]),
        .high_time(ht[1]), .period_valid(pv[1]), .timeout(to[1]));

    period_meter #(.TIMEOUT(32'd8), .SYNC_STAGES(3)) dut_c (
        .clock_in(clk), .clear(clr[2]), .sig_in(sig[2]), .period(per[2]),
        .high_time(ht[2]), .period_valid(pv[2]), .timeout(to[2]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pv[i] === 1'b1 && pv_prev[i] === 1'b1) wide <= 1'b1;
            pv_prev[i] <= pv[i];
        end
        if (rnd && pv[0] === 1'b1) begin
            rnd_n <= rnd_n + 1;
            if (per[0] < pmin) pmin <= per[0];
            if (per[0] > pmax) pmax <= per[0];
            if (ht[0] < hmin) hmin <= ht[0];
            if (ht[0] > hmax) hmax <= ht[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic seen(input int d, input logic [31:0] ep, input logic [31:0] eh, inout int nv);
        if (pv[d] === 1'b1) begin
            nv++;
            chk("period", per[d], ep);
            chk("high_time", ht[d], eh);
            chk("timeout_on_valid", {31'b0, to[d]}, 32'd0);
        end
    endtask

    task automatic train(input int d, input int hi, input int lo, input int reps,
                         input logic [31:0] ep, input logic [31:0] eh, output int nv);
        nv = 0;
        for (int r = 0; r < reps; r++)
            for (int c = 0; c < hi + lo; c++) begin
                sig[d] = (c < hi);
                tick(1);
                seen(d, ep, eh, nv);
            end
        for (int c = 0; c < 6; c++) begin
            sig[d] = 1'b0;
            tick(1);
            seen(d, ep, eh, nv);
        end
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b1;
            sig[i] = 1'b0;
        end
        sig[0] = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) clr[i] = 1'b0;
        chk("rst_period", per[0], 32'd0);
        chk("rst_high_time", ht[0], 32'd0);
        chk("rst_valid", {31'b0, pv[0]}, 32'd0);
        chk("rst_timeout", {31'b0, to[0]}, 32'd0);

        tick(4);
        chk("no_spurious_valid", {31'b0, pv[0]}, 32'd0);
        chk("no_spurious_arm", {31'b0, dut_a.state == IDLE}, 32'd1);
        sig[0] = 1'b0;
        tick(5);

        train(0, 3, 5, 5, 32'd8, 32'd3, nv);
        chk("n_valid_3_5", nv, 32'd4);

        sig[0] = 1'b1;
        tick(1); chk("lat_e0", {31'b0, pv[0]}, 32'd0);
        tick(1); chk("lat_e1", {31'b0, pv[0]}, 32'd0);
        tick(1); chk("lat_e2", {31'b0, pv[0]}, 32'd0);
        tick(1); chk("lat_e3", {31'b0, pv[0]}, 32'd1);
        chk("lat_period", per[0], 32'd14);
        chk("lat_high_time", ht[0], 32'd3);
        tick(1); chk("valid_one_cycle", {31'b0, pv[0]}, 32'd0);

        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_period", per[0], 32'd0);
        chk("clr_high_time", ht[0], 32'd0);
        chk("clr_valid", {31'b0, pv[0]}, 32'd0);
        chk("clr_timeout", {31'b0, to[0]}, 32'd0);
        tick(3);
        sig[0] = 1'b0;
        tick(4);
        chk("clr_no_valid", {31'b0, pv[0]}, 32'd0);
        train(0, 1000, 1000, 3, 32'd2000, 32'd1000, nv);
        chk("n_valid_long", nv, 32'd2);

        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        tick(4);
        #($urandom_range(0, 9) * 2);
        rnd = 1'b1;
        repeat (10) begin
            sig[0] = 1'b1;
            #162;
            sig[0] = 1'b0;
            #164;
        end
        tick(6);
        rnd = 1'b0;
        tick(1);
        chk("rnd_n_valid", rnd_n, 32'd9);
        chk("rnd_period_range", {31'b0, pmin >= 32'd16 && pmax <= 32'd17}, 32'd1);
        chk("rnd_high_range", {31'b0, hmin >= 32'd8 && hmax <= 32'd9}, 32'd1);

        sig[1] = 1'b1;
        tick(3);
        sig[1] = 1'b0;
        tick(20);
        chk("to_before", {31'b0, to[1]}, 32'd0);
        tick(1);
        chk("to_set", {31'b0, to[1]}, 32'd1);
        chk("to_idle", {31'b0, dut_b.state == IDLE}, 32'd1);
        chk("to_period_held", per[1], 32'd0);
        chk("to_no_valid", {31'b0, pv[1]}, 32'd0);
        tick(5);
        chk("to_sticky", {31'b0, to[1]}, 32'd1);
        train(1, 3, 5, 2, 32'd8, 32'd3, nv);
        chk("to_n_valid", nv, 32'd1);

        train(2, 3, 5, 4, 32'd8, 32'd3, nv);
        chk("bound_n_valid", nv, 32'd3);

        chk("valid_width", {31'b0, wide}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
